dcache_ctrl: RTL and testbench

DCACHE_CTRL -- requirements
Module: dcache_ctrl

---
 rtl/dcache_ctrl_pkg.sv | 14 +
 rtl/dcache_beat_counter.sv | 45 ++++
 rtl/dcache_ctrl.sv | 141 ++++++++++++++
 tb/tb_dcache_ctrl.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/dcache_ctrl_pkg.sv
// dcache_ctrl_pkg: shared types and defaults for the data-cache miss controller.
//   t_dcache_state      - controller states (IDLE, WRITE_BACK, ALLOCATE)
//   DCACHE_BLOCK_WORDS  - default number of words per cache line
package dcache_ctrl_pkg;

    localparam int unsigned DCACHE_BLOCK_WORDS = 8;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WRITE_BACK = 2'd1,
        ALLOCATE   = 2'd2
    } t_dcache_state;

endpackage

// File: rtl/dcache_beat_counter.sv
// dcache_beat_counter: beat index within a cache line, shared by the
// write-back and fill transfers.
//   clk, rst  - clock, synchronous active-high reset (count -> 0)
//   inc_i     - advance by one beat (wraps naturally at 2**CW)
//   clr_i     - force count to 0 (takes priority over inc_i)
//   cnt_o     - current beat index
//   last_o    - current beat is the final beat of the line
module dcache_beat_counter
    import dcache_ctrl_pkg::*;
#(
    parameter int unsigned CW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc_i,
    input  logic          clr_i,
    output logic [CW-1:0] cnt_o,
    output logic          last_o
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    // Line length is a power of two, so the final beat is the all-ones index.
    assign last_o = &cnt_q;

endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: data-cache miss controller. Hits complete in IDLE with zero
// latency; a miss optionally writes back the dirty victim line and then
// fills the line from memory, after which the held request is retried.
//   clk, rst           - clock, synchronous active-high reset
//   i_start_d_cache    - access request, held until o_stall_data=0
//   i_write            - 1=store, 0=load
//   i_hit, i_dirty     - tag match/valid and victim-dirty for current index
//   o_stall_data       - access not complete this cycle
//   o_mem_rd_req       - line-fill request; i_mem_rd_valid marks a fill word
//   o_mem_wr_valid     - write-back word offered; i_mem_wr_ready accepts it
//   o_word_cnt         - beat index into the line
//   o_refill_we        - write fill word into data array
//   o_store_we         - write CPU store word into hit line
//   o_tag_we, o_valid_set, o_dirty_set, o_dirty_clear - metadata updates
//   o_wb_addr_sel      - memory address from victim tag (1) / request tag (0)
module dcache_ctrl
    import dcache_ctrl_pkg::*;
#(
    parameter  int unsigned BLOCK_WORDS = DCACHE_BLOCK_WORDS,
    localparam int unsigned CW          = $clog2(BLOCK_WORDS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_start_d_cache,
    input  logic          i_write,
    input  logic          i_hit,
    input  logic          i_dirty,
    output logic          o_stall_data,
    output logic          o_mem_rd_req,
    input  logic          i_mem_rd_valid,
    output logic          o_mem_wr_valid,
    input  logic          i_mem_wr_ready,
    output logic [CW-1:0] o_word_cnt,
    output logic          o_refill_we,
    output logic          o_store_we,
    output logic          o_tag_we,
    output logic          o_valid_set,
    output logic          o_dirty_set,
    output logic          o_dirty_clear,
    output logic          o_wb_addr_sel
);

    t_dcache_state state_q;
    t_dcache_state state_d;

    logic cnt_inc;
    logic cnt_clr;
    logic cnt_last;

    dcache_beat_counter #(
        .CW(CW)
    ) u_beat_cnt (
        .clk    (clk),
        .rst    (rst),
        .inc_i  (cnt_inc),
        .clr_i  (cnt_clr),
        .cnt_o  (o_word_cnt),
        .last_o (cnt_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (i_start_d_cache && !i_hit) begin
                    state_d = i_dirty ? WRITE_BACK : ALLOCATE;
                end
            end
            WRITE_BACK: begin
                if (i_mem_wr_ready && cnt_last) begin
                    state_d = ALLOCATE;
                end
            end
            ALLOCATE: begin
                if (i_mem_rd_valid && cnt_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are forced low while rst is high so that a reset landing on
    // the final fill beat cannot commit tag/valid/dirty updates.
    always_comb begin
        o_stall_data   = 1'b0;
        o_mem_rd_req   = 1'b0;
        o_mem_wr_valid = 1'b0;
        o_refill_we    = 1'b0;
        o_store_we     = 1'b0;
        o_tag_we       = 1'b0;
        o_valid_set    = 1'b0;
        o_dirty_set    = 1'b0;
        o_dirty_clear  = 1'b0;
        o_wb_addr_sel  = 1'b0;
        cnt_inc        = 1'b0;
        cnt_clr        = 1'b0;
        if (!rst) begin
            unique case (state_q)
                IDLE: begin
                    cnt_clr = 1'b1;
                    if (i_start_d_cache) begin
                        if (i_hit) begin
                            o_store_we  = i_write;
                            o_dirty_set = i_write;
                        end else begin
                            o_stall_data = 1'b1;
                        end
                    end
                end
                WRITE_BACK: begin
                    o_stall_data   = 1'b1;
                    o_mem_wr_valid = 1'b1;
                    o_wb_addr_sel  = 1'b1;
                    cnt_inc        = i_mem_wr_ready;
                end
                ALLOCATE: begin
                    o_stall_data  = 1'b1;
                    o_mem_rd_req  = 1'b1;
                    o_refill_we   = i_mem_rd_valid;
                    cnt_inc       = i_mem_rd_valid;
                    o_tag_we      = i_mem_rd_valid && cnt_last;
                    o_valid_set   = i_mem_rd_valid && cnt_last;
                    o_dirty_clear = i_mem_rd_valid && cnt_last;
                end
                default: begin
                    cnt_clr = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
module tb_dcache_ctrl;

    localparam int unsigned N = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_start_d_cache = 1'b0;
    logic       i_write = 1'b0;
    logic       i_hit = 1'b0;
    logic       i_dirty = 1'b0;
    logic       i_mem_rd_valid = 1'b0;
    logic       i_mem_wr_ready = 1'b0;
    logic       o_stall_data, o_mem_rd_req, o_mem_wr_valid;
    logic [2:0] o_word_cnt;
    logic       o_refill_we, o_store_we, o_tag_we, o_valid_set;
    logic       o_dirty_set, o_dirty_clear, o_wb_addr_sel;

    dcache_ctrl #(.BLOCK_WORDS(N)) dut (
        .clk             (clk),
        .rst             (rst),
        .i_start_d_cache (i_start_d_cache),
        .i_write         (i_write),
        .i_hit           (i_hit),
        .i_dirty         (i_dirty),
        .o_stall_data    (o_stall_data),
        .o_mem_rd_req    (o_mem_rd_req),
        .i_mem_rd_valid  (i_mem_rd_valid),
        .o_mem_wr_valid  (o_mem_wr_valid),
        .i_mem_wr_ready  (i_mem_wr_ready),
        .o_word_cnt      (o_word_cnt),
        .o_refill_we     (o_refill_we),
        .o_store_we      (o_store_we),
        .o_tag_we        (o_tag_we),
        .o_valid_set     (o_valid_set),
        .o_dirty_set     (o_dirty_set),
        .o_dirty_clear   (o_dirty_clear),
        .o_wb_addr_sel   (o_wb_addr_sel)
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: a single-line cache (tag/valid/dirty) and a pending
    // miss described only as "beats still owed" to each transfer direction.
    int  wb_rem, fill_rem;
    bit  req_active, req_write;
    int  req_tag;
    bit  line_valid, line_dirty;
    int  line_tag;

    bit  idle, hit_now;
    int  e_cnt;
    bit  e_stall, e_rdreq, e_wrvalid, e_refill, e_store, e_tag, e_vset;
    bit  e_dset, e_dclr, e_wbsel;
    int  mode;

    initial begin
        wb_rem = 0; fill_rem = 0;
        req_active = 0; req_write = 0; req_tag = 0;
        line_valid = 0; line_dirty = 0; line_tag = 0;

        for (int cyc = 0; cyc < 2100; cyc++) begin
            @(negedge clk);
            mode = cyc / 700;
            rst  = (cyc < 2) || ($urandom_range(0, 149) == 0);
            idle = (wb_rem == 0) && (fill_rem == 0);

            if (idle && !req_active && $urandom_range(0, 3) != 0) begin
                req_active = 1;
                req_write  = 1'($urandom_range(0, 1));
                req_tag    = int'($urandom_range(0, 3));
            end
            if (!idle && req_active && $urandom_range(0, 15) == 0)
                req_active = 0;

            i_start_d_cache = req_active;
            i_write = req_active ? req_write : 1'($urandom_range(0, 1));
            hit_now = line_valid && (line_tag == req_tag);
            if (idle && req_active) begin
                i_hit   = hit_now;
                i_dirty = line_valid && line_dirty;
            end else begin
                i_hit   = 1'($urandom_range(0, 1));
                i_dirty = 1'($urandom_range(0, 1));
            end
            case (mode)
                0:       begin i_mem_rd_valid = 1'b1; i_mem_wr_ready = 1'b1; end
                1:       begin i_mem_rd_valid = 1'($urandom_range(0, 1));
                               i_mem_wr_ready = 1'($urandom_range(0, 1)); end
                default: begin i_mem_rd_valid = cyc[0]; i_mem_wr_ready = cyc[0]; end
            endcase

            #1;
            e_stall = 0; e_rdreq = 0; e_wrvalid = 0; e_refill = 0; e_store = 0;
            e_tag = 0; e_vset = 0; e_dset = 0; e_dclr = 0; e_wbsel = 0; e_cnt = 0;
            if (idle) begin
                if (req_active) begin
                    e_stall = !hit_now;
                    e_store = hit_now && req_write;
                    e_dset  = hit_now && req_write;
                end
            end else if (wb_rem > 0) begin
                e_stall = 1; e_wrvalid = 1; e_wbsel = 1;
                e_cnt   = int'(N) - wb_rem;
            end else begin
                e_stall  = 1; e_rdreq = 1;
                e_cnt    = int'(N) - fill_rem;
                e_refill = i_mem_rd_valid;
                e_tag    = i_mem_rd_valid && (fill_rem == 1);
                e_vset   = e_tag;
                e_dclr   = e_tag;
            end
            if (rst) begin
                e_stall = 0; e_rdreq = 0; e_wrvalid = 0; e_refill = 0; e_store = 0;
                e_tag = 0; e_vset = 0; e_dset = 0; e_dclr = 0; e_wbsel = 0;
            end

            chk("stall",      o_stall_data,   e_stall);
            chk("mem_rd_req", o_mem_rd_req,   e_rdreq);
            chk("mem_wr_vld", o_mem_wr_valid, e_wrvalid);
            chk("word_cnt",   o_word_cnt,     e_cnt);
            chk("refill_we",  o_refill_we,    e_refill);
            chk("store_we",   o_store_we,     e_store);
            chk("tag_we",     o_tag_we,       e_tag);
            chk("valid_set",  o_valid_set,    e_vset);
            chk("dirty_set",  o_dirty_set,    e_dset);
            chk("dirty_clr",  o_dirty_clear,  e_dclr);
            chk("wb_addr_sel", o_wb_addr_sel, e_wbsel);
            chk("store_refill_excl", o_store_we & o_refill_we, 1'b0);

            // Advance the model to reflect the upcoming clock edge.
            if (rst) begin
                wb_rem = 0;
                fill_rem = 0;
            end else if (idle) begin
                if (req_active) begin
                    if (hit_now) begin
                        if (req_write) line_dirty = 1;
                        req_active = 0;
                    end else begin
                        wb_rem   = (line_valid && line_dirty) ? int'(N) : 0;
                        fill_rem = int'(N);
                    end
                end
            end else if (wb_rem > 0) begin
                if (i_mem_wr_ready) wb_rem--;
            end else if (i_mem_rd_valid) begin
                if (fill_rem == 1) begin
                    line_valid = 1;
                    line_dirty = 0;
                    line_tag   = req_tag;
                end
                fill_rem--;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
